// File: rtl/dpe_pkg.sv
// dpe_pkg: shared definitions for the DPE egress demultiplexer.
//   - DPE_ADDR_*     : route-table index codes carried in tuser_dst
//   - DPE_PORT_*     : output port indices (0 = CPU, 1..4 = ETH)
//   - dpe_beat_t     : one stream beat at the default field widths
//   - dpe_rt_default : route-table contents after reset
package dpe_pkg;

  localparam int unsigned DPE_NUM_PORTS = 5;
  localparam int unsigned DPE_DATA_W    = 128;
  localparam int unsigned DPE_KEEP_W    = DPE_DATA_W / 8;
  localparam int unsigned DPE_SRC_W     = 3;
  localparam int unsigned DPE_DST_W     = 3;

  // Widest port mask the reset-table helper can describe.
  localparam int unsigned DPE_MASK_MAX_W = 32;

  localparam logic [DPE_DST_W-1:0] DPE_ADDR_CPU      = 3'd0;
  localparam logic [DPE_DST_W-1:0] DPE_ADDR_ETH_1    = 3'd1;
  localparam logic [DPE_DST_W-1:0] DPE_ADDR_ETH_2    = 3'd2;
  localparam logic [DPE_DST_W-1:0] DPE_ADDR_ETH_3    = 3'd3;
  localparam logic [DPE_DST_W-1:0] DPE_ADDR_ETH_4    = 3'd4;
  localparam logic [DPE_DST_W-1:0] DPE_ADDR_UNMAPPED = 3'd5;
  localparam logic [DPE_DST_W-1:0] DPE_ADDR_MCAST_13 = 3'd6;
  localparam logic [DPE_DST_W-1:0] DPE_ADDR_BCAST    = 3'd7;

  localparam int unsigned DPE_PORT_CPU   = 0;
  localparam int unsigned DPE_PORT_ETH_1 = 1;
  localparam int unsigned DPE_PORT_ETH_2 = 2;
  localparam int unsigned DPE_PORT_ETH_3 = 3;
  localparam int unsigned DPE_PORT_ETH_4 = 4;

  // Ports 1 and 3 (ETH_1 + ETH_3).
  localparam logic [DPE_MASK_MAX_W-1:0] DPE_MCAST_13_MASK =
      (DPE_MASK_MAX_W'(1) << DPE_PORT_ETH_1) | (DPE_MASK_MAX_W'(1) << DPE_PORT_ETH_3);

  typedef struct packed {
    logic [DPE_DATA_W-1:0] tdata;
    logic [DPE_KEEP_W-1:0] tkeep;
    logic                  tlast;
    logic                  tuser_bypass_all;
    logic                  tuser_bypass_stage;
    logic [DPE_SRC_W-1:0]  tuser_src;
    logic [DPE_DST_W-1:0]  tuser_dst;
  } dpe_beat_t;

  // Reset route-table entry: one-hot for direct port codes, then the
  // multicast and broadcast codes; anything else drops.
  function automatic logic [DPE_MASK_MAX_W-1:0] dpe_rt_default(input int unsigned idx,
                                                               input int unsigned num_ports);
    logic [DPE_MASK_MAX_W-1:0] mask;
    mask = '0;
    if (idx < num_ports) begin
      mask = DPE_MASK_MAX_W'(1) << idx;
    end else if (idx == 32'(DPE_ADDR_MCAST_13)) begin
      mask = DPE_MCAST_13_MASK;
    end else if (idx == 32'(DPE_ADDR_BCAST)) begin
      mask = (num_ports >= DPE_MASK_MAX_W) ? '1 : ((DPE_MASK_MAX_W'(1) << num_ports) - 1'b1);
    end
    return mask;
  endfunction

endpackage

// File: rtl/dpe_demux_port_reg.sv
// dpe_demux_port_reg: single-entry output register with valid/ready.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load, din       capture din this cycle (caller only loads when can_load)
//   ready           downstream ready
//   valid, dout     registered output beat
//   can_load        slot is free or draining this cycle
module dpe_demux_port_reg
  import dpe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             can_load
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign can_load = !valid_q || ready;
  assign valid    = valid_q;
  assign dout     = data_q;

  // Load wins over drain so a simultaneous drain+load keeps streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= din;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/dpe_demux_rt.sv
// dpe_demux_rt: N-way DPE stream demultiplexer with a CPU-programmable
// route table (unicast / multicast / broadcast / drop).
// Optional build macro: DPE_DEMUX_HAIRPIN_BLOCK_EN removes the ingress port
// (tuser_src) from the looked-up mask so packets never echo back.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   s_t*                        input stream (valid/ready, data, keep, last, user)
//   m_t*                        per-port output streams, port p at slice p
//   rt_we, rt_waddr, rt_wmask   route-table write port
//   drop_cnt                    saturating count of dropped packets
module dpe_demux_rt
  import dpe_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned DATA_W    = 128,
  localparam int unsigned KEEP_W   = DATA_W / 8,
  parameter int unsigned SRC_W     = 3,
  parameter int unsigned DST_W     = 3,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [DATA_W-1:0]             s_tdata,
  input  logic [KEEP_W-1:0]             s_tkeep,
  input  logic                          s_tlast,
  input  logic                          s_tuser_bypass_all,
  input  logic                          s_tuser_bypass_stage,
  input  logic [SRC_W-1:0]              s_tuser_src,
  input  logic [DST_W-1:0]              s_tuser_dst,
  output logic [NUM_PORTS-1:0]          m_tvalid,
  input  logic [NUM_PORTS-1:0]          m_tready,
  output logic [NUM_PORTS*DATA_W-1:0]   m_tdata,
  output logic [NUM_PORTS*KEEP_W-1:0]   m_tkeep,
  output logic [NUM_PORTS-1:0]          m_tlast,
  output logic [NUM_PORTS-1:0]          m_tuser_bypass_all,
  output logic [NUM_PORTS-1:0]          m_tuser_bypass_stage,
  output logic [NUM_PORTS*SRC_W-1:0]    m_tuser_src,
  output logic [NUM_PORTS*DST_W-1:0]    m_tuser_dst,
  input  logic                          rt_we,
  input  logic [DST_W-1:0]              rt_waddr,
  input  logic [NUM_PORTS-1:0]          rt_wmask,
  output logic [CNT_W-1:0]              drop_cnt
);

  localparam int unsigned RT_DEPTH = 2 ** DST_W;
  localparam int unsigned BEAT_W   = DATA_W + KEEP_W + 3 + SRC_W + DST_W;

  logic [NUM_PORTS-1:0] rt_q [RT_DEPTH];
  logic                 in_pkt_q;
  logic [NUM_PORTS-1:0] held_mask_q;
  logic [CNT_W-1:0]     drop_cnt_q;

  logic [NUM_PORTS-1:0] cur_mask;
  logic [NUM_PORTS-1:0] sel_mask;
  logic [NUM_PORTS-1:0] can_load;
  logic [NUM_PORTS-1:0] load;
  logic                 accept;
  logic [BEAT_W-1:0]    beat_in;

  // ---------------------------------------------------------------------------
  // Route lookup. The table is read from the registered copy, so a write to
  // the same entry in the same cycle is only seen from the next cycle on.
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_mask = rt_q[s_tuser_dst];
`ifdef DPE_DEMUX_HAIRPIN_BLOCK_EN
    if (32'(s_tuser_src) < NUM_PORTS) begin
      cur_mask = cur_mask & ~(NUM_PORTS'(1) << s_tuser_src);
    end
`endif
  end

  // Mid-packet beats follow the mask latched on the first beat; later
  // tuser_dst values and table writes cannot redirect them.
  assign sel_mask = in_pkt_q ? held_mask_q : cur_mask;

  // Only selected ports can stall the input; an empty mask always accepts.
  assign s_tready = &(~sel_mask | can_load);
  assign accept   = s_tvalid && s_tready;
  assign load     = accept ? sel_mask : '0;

  assign beat_in = {s_tdata, s_tkeep, s_tlast, s_tuser_bypass_all, s_tuser_bypass_stage,
                    s_tuser_src, s_tuser_dst};

  // ---------------------------------------------------------------------------
  // Route table
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RT_DEPTH; i++) begin
        rt_q[i] <= NUM_PORTS'(dpe_rt_default(i, NUM_PORTS));
      end
    end else if (rt_we) begin
      rt_q[rt_waddr] <= rt_wmask;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet tracking: mask latched on the first accepted beat, in_pkt held
  // until the accepted tlast. Single-beat packets never set in_pkt.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt_q    <= 1'b0;
      held_mask_q <= '0;
    end else if (accept) begin
      if (!in_pkt_q) begin
        held_mask_q <= cur_mask;
      end
      in_pkt_q <= !s_tlast;
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter: one count per dropped packet, saturating.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (accept && s_tlast && (sel_mask == '0) && !(&drop_cnt_q)) begin
      drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign drop_cnt = drop_cnt_q;

  // ---------------------------------------------------------------------------
  // Per-port output registers
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [BEAT_W-1:0] dout;

    dpe_demux_port_reg #(
      .WIDTH (BEAT_W)
    ) u_port_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (load[p]),
      .din      (beat_in),
      .ready    (m_tready[p]),
      .valid    (m_tvalid[p]),
      .dout     (dout),
      .can_load (can_load[p])
    );

    assign {m_tdata[p*DATA_W +: DATA_W], m_tkeep[p*KEEP_W +: KEEP_W], m_tlast[p],
            m_tuser_bypass_all[p], m_tuser_bypass_stage[p], m_tuser_src[p*SRC_W +: SRC_W],
            m_tuser_dst[p*DST_W +: DST_W]} = dout;
  end

endmodule

// File: doc/dpe_demux_rt.md
Name: dpe_demux_rt

Overview:
- Parametrised N-way DPE stream demultiplexer with unicast, multicast and broadcast fan-out.
- A CPU-programmable route table maps tuser_dst codes to port bitmasks; the mask is latched once per packet.
- Each output has its own registered stage; all ports selected by the mask advance in lockstep.
- Sits at the DPE egress, between the pipeline and the CPU/Ethernet ports.

Parameters:
- NUM_PORTS, 5, number of output ports (port 0 = CPU, 1..4 = ETH).
- DATA_W, 128, tdata width; KEEP_W = DATA_W/8.
- SRC_W, 3, tuser_src width.
- DST_W, 3, tuser_dst width; route table depth RT_DEPTH = 2**DST_W.
- CNT_W, 32, drop counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_tvalid/s_tready  in/out  1  input handshake
- s_tdata  in  DATA_W
- s_tkeep  in  KEEP_W
- s_tlast  in  1
- s_tuser_bypass_all  in  1
- s_tuser_bypass_stage  in  1
- s_tuser_src  in  SRC_W
- s_tuser_dst  in  DST_W
- m_tvalid  out  NUM_PORTS  per-port valid
- m_tready  in  NUM_PORTS  per-port ready
- m_tdata/m_tkeep/m_tlast/m_tuser_*  out  NUM_PORTS× field width  per-port copies, flattened, port p at slice p
- rt_we  in  1  route table write strobe
- rt_waddr  in  DST_W  entry index
- rt_wmask  in  NUM_PORTS  port mask to write
- drop_cnt  out  CNT_W  dropped-packet count, saturating

Behaviour:
- Reset: m_tvalid=0; all m_t* data=0; drop_cnt=0; in_pkt=0; the route table is set so that entry i = (1<<i) for i<NUM_PORTS, entry 6 = 5'b01010 (MCAST_13), entry 7 = all ones (BCAST), all other entries 0.
- Route latch, at the first beat (in_pkt=0): cur_mask = rt[s_tuser_dst].
  - The lookup reads pre-write contents when rt_we hits the same entry in the same cycle; the write is visible from the next cycle.
  - sel_mask = in_pkt ? held_mask : cur_mask.
  - held_mask is registered on the first accepted beat; in_pkt sets on accept with !tlast and clears on accepted tlast.
  - Table writes mid-packet never alter the packet in flight.
- Ready: s_tready = AND over p with sel_mask[p] of (!m_tvalid[p] | m_tready[p]).
  - With sel_mask == 0, s_tready = 1 (drop mode).
  - s_tready never depends on unselected ports.
- Accept (s_tvalid & s_tready): for each p with sel_mask[p], load port p's output register with all fields and set m_tvalid[p]=1. Latency is 1 cycle.
- Port p clears m_tvalid[p] on m_tready[p] when it is not reloaded in the same cycle. A simultaneous drain and load keeps valid=1 with new data, giving full throughput.
- Output data is held stable while m_tvalid[p] & !m_tready[p] (AXIS rule).
- Drop: packets with sel_mask==0 are consumed beat by beat with no outputs. drop_cnt increments by 1 on the accepted tlast beat and saturates at all ones.
- A single-beat packet (first beat has tlast) does not set in_pkt.
- Reset mid-packet: all state returns to reset values; the partial packet is discarded and no tlast is emitted.
- tuser_dst of later beats is ignored.

Optional Feature:
- DPE_DEMUX_HAIRPIN_BLOCK_EN.
- When defined: before latching, cur_mask is ANDed with ~(1<<s_tuser_src) when s_tuser_src < NUM_PORTS. This prevents a packet echoing back to its ingress port; a mask that becomes 0 is dropped and counted.
- When undefined: the mask is used unmodified.

Decomposition:
- dpe_pkg holds:
  - DPE_ADDR_* codes;
  - the port index constants DPE_PORT_CPU=0 and DPE_PORT_ETH_1..4=1..4;
  - the reset route-table function dpe_rt_default(idx) returning a NUM_PORTS mask;
  - the dpe_beat_t struct (tdata, tkeep, tlast, tuser fields).
- Sub-module dpe_demux_port_reg: a single-entry output register with valid/ready, instantiated NUM_PORTS times via generate.

Test Plan:
- Unicast, dst=2, 3-beat packet, all ready: only m_tvalid[2] pulses for 3 consecutive cycles starting 1 cycle after accept; tdata/tlast match the input; other ports stay 0.
- Broadcast, dst=7, m_tready[3]=0 for 4 cycles: s_tready=0 throughout and no port advances; after release all 5 ports receive identical beats in lockstep.
- rt_we writes entry 2 := 5'b10001 in the middle of a dst=2 packet: the rest of that packet still goes to port 2 only; the next dst=2 packet goes to ports 0 and 4.
- Entry 5 = 0 and a 4-beat packet to dst=5: s_tready=1 for all beats, no m_tvalid, drop_cnt 0→1. Force drop_cnt to all ones and send another dropped packet: the count holds at max.
- Assert rst during beat 2 of a broadcast packet: the next cycle m_tvalid=0 and in_pkt=0; the following packet's first beat routes by its own dst.
- With DPE_DEMUX_HAIRPIN_BLOCK_EN defined, src=1 and dst=7: ports 0, 2, 3, 4 receive the packet and port 1 does not. Without the macro, all 5 ports receive it.
